// File: rtl/spike_window_monitor.sv
// Rate-coded winner per window: counts SNN output spikes per time step, classifies each window, queues results.
// Latency: a window result is visible at the FIFO head one cycle after the closing step edge.
// Backpressure: none upstream; a result arriving at a full FIFO with no pop is dropped and flagged in the sticky overflow.
//
// Ports:
//   system_clock  : sole clock, rising edge
//   reset         : asynchronous active-high, clears all state
//   enable        : 0 ignores step pulses, counts and step index hold
//   step_tick     : time-step strobe (system_clock domain), rising edge = one step
//   output_spikes : [1:0] neuron spikes, sampled on step cycles
//   window_len    : steps per window, 0 means 256, read live
//   rd_en         : pops the FIFO head when result_valid is high
//   result_data   : FIFO head {class, count1, count0}, 0 when empty
//   result_valid  : FIFO non-empty
//   fifo_count    : FIFO occupancy
//   overflow      : sticky, a window result was dropped
//   step_index    : steps completed in the current window
module spike_window_monitor #(
    parameter int FIFO_DEPTH = 4,   // power of two, at least 2
    parameter int CNT_W      = 8
) (
    input  logic                                 system_clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 step_tick,
    input  logic [1:0]                           output_spikes,
    input  logic [7:0]                           window_len,
    input  logic                                 rd_en,
    output logic [2*CNT_W+1:0]                   result_data,
    output logic                                 result_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 overflow,
    output logic [7:0]                           step_index
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = $clog2(FIFO_DEPTH+1);
    localparam int RES_W = 2*CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // window / counting state
    logic               r_tick_d;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;
    logic [7:0]         r_step_index;

    // result FIFO state
    logic [RES_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCW-1:0]     r_count;
    logic               r_overflow;

    logic               w_step;
    logic [CNT_W-1:0]   w_cnt0_nxt;
    logic [CNT_W-1:0]   w_cnt1_nxt;
    logic [8:0]         w_win_len;
    logic [8:0]         w_idx_plus1;
    logic               w_win_end;
    logic [1:0]         w_class;
    logic [RES_W-1:0]   w_result;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    // tick_d tracks step_tick even while disabled, so a tick held high
    // across enable rising does not produce a late step.
    assign w_step = step_tick & ~r_tick_d & enable;

    // Saturating increments; these are also the final counts used for
    // classification when this step closes the window.
    assign w_cnt0_nxt = (output_spikes[0] && (r_cnt0 != CNT_MAX)) ? r_cnt0 + CNT_W'(1) : r_cnt0;
    assign w_cnt1_nxt = (output_spikes[1] && (r_cnt1 != CNT_MAX)) ? r_cnt1 + CNT_W'(1) : r_cnt1;

    // 9-bit compare so a window length of 0 can stand for 256.
    assign w_win_len   = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
    assign w_idx_plus1 = {1'b0, r_step_index} + 9'd1;
    assign w_win_end   = w_step && (w_idx_plus1 >= w_win_len);

    always_comb begin
        w_class = 2'b00;
        if ((w_cnt0_nxt == '0) && (w_cnt1_nxt == '0)) begin
            w_class = 2'b00;
        end else if (w_cnt0_nxt > w_cnt1_nxt) begin
            w_class = 2'b01;
        end else if (w_cnt1_nxt > w_cnt0_nxt) begin
            w_class = 2'b10;
        end else begin
            w_class = 2'b11;
        end
    end

    assign w_result = {w_class, w_cnt1_nxt, w_cnt0_nxt};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FCW'(FIFO_DEPTH));
    assign w_pop   = rd_en & ~w_empty;
    // When full, a simultaneous pop frees the slot the write lands in
    // (wr_ptr == rd_ptr), so both proceed.
    assign w_wr    = w_win_end & (~w_full | w_pop);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_tick_d     <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
            r_step_index <= '0;
        end else begin
            r_tick_d <= step_tick;
            if (w_win_end) begin
                r_cnt0       <= '0;
                r_cnt1       <= '0;
                r_step_index <= '0;
            end else if (w_step) begin
                r_cnt0       <= w_cnt0_nxt;
                r_cnt1       <= w_cnt1_nxt;
                r_step_index <= r_step_index + 8'd1;
            end
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + FCW'(1);
                2'b01:   r_count <= r_count - FCW'(1);
                default: r_count <= r_count;
            endcase
            if (w_win_end && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is presented while the count is 0.
    always_ff @(posedge system_clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign result_valid = ~w_empty;
    assign result_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign step_index   = r_step_index;

endmodule

// File: tb/tb_spike_window_monitor.sv
module tb_spike_window_monitor;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        step_tick;
    logic [1:0]  output_spikes;
    logic [7:0]  window_len;
    logic        rd_en;
    logic [17:0] result_data;
    logic        result_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  step_index;

    int checks = 0;
    int errors = 0;

    // scoreboard and reference model
    logic [17:0] exp_q[$];
    int          m_c0;
    int          m_c1;
    int          m_idx;
    logic        m_ovf;

    spike_window_monitor #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .system_clock  (system_clock),
        .reset         (reset),
        .enable        (enable),
        .step_tick     (step_tick),
        .output_spikes (output_spikes),
        .window_len    (window_len),
        .rd_en         (rd_en),
        .result_data   (result_data),
        .result_valid  (result_valid),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .step_index    (step_index)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge system_clock);
        #1;
    endtask

    function automatic logic [17:0] mk(input int c0, input int c1);
        logic [1:0] cls;
        if (c0 == 0 && c1 == 0)  cls = 2'b00;
        else if (c0 > c1)        cls = 2'b01;
        else if (c1 > c0)        cls = 2'b10;
        else                     cls = 2'b11;
        return {cls, 8'(c1), 8'(c0)};
    endfunction

    task automatic push_exp(input logic [17:0] v);
        if (exp_q.size() < 4) exp_q.push_back(v);
        else                  m_ovf = 1'b1;
    endtask

    // Model of one step cycle, applied when the bench drives a rising tick.
    task automatic model_step(input logic [1:0] s);
        int len;
        if (enable) begin
            if (s[0] && m_c0 < 255) m_c0++;
            if (s[1] && m_c1 < 255) m_c1++;
            m_idx++;
            len = (window_len == 8'd0) ? 256 : int'(window_len);
            if (m_idx >= len) begin
                push_exp(mk(m_c0, m_c1));
                m_idx = 0;
                m_c0  = 0;
                m_c1  = 0;
            end
        end
    endtask

    task automatic do_step(input logic [1:0] s);
        output_spikes = s;
        step_tick     = 1'b1;
        model_step(s);
        cyc();
        step_tick     = 1'b0;
        output_spikes = 2'b00;
        cyc();
    endtask

    // Window-end step with rd_en asserted in the same cycle.
    task automatic step_pop(input string tag, input logic [1:0] s);
        chk({tag, " head"}, {14'd0, result_data}, {14'd0, exp_q.pop_front()});
        rd_en         = 1'b1;
        output_spikes = s;
        step_tick     = 1'b1;
        model_step(s);
        cyc();
        rd_en         = 1'b0;
        step_tick     = 1'b0;
        output_spikes = 2'b00;
        cyc();
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, " valid"}, {31'd0, result_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard nonempty"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " data"}, {14'd0, result_data}, {14'd0, exp_q.pop_front()});
        end
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " fifo_count"}, {29'd0, fifo_count}, 32'(exp_q.size()));
        chk({tag, " step_index"}, {24'd0, step_index}, 32'(m_idx));
        chk({tag, " overflow"},   {31'd0, overflow},   {31'd0, m_ovf});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " result_data"},  {14'd0, result_data},  32'd0);
        chk({tag, " result_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, " fifo_count"},   {29'd0, fifo_count},   32'd0);
        chk({tag, " overflow"},     {31'd0, overflow},     32'd0);
        chk({tag, " step_index"},   {24'd0, step_index},   32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; step_tick = 1'b0; output_spikes = 2'b00;
        window_len = 8'd4; rd_en = 1'b0;
        m_c0 = 0; m_c1 = 0; m_idx = 0; m_ovf = 1'b0;
        cyc(); cyc();
        chk_all_zero("reset");
        reset = 1'b0;
        enable = 1'b1;
        cyc();

        // basic 4-step window
        do_step(2'b01); do_step(2'b01); do_step(2'b11);
        chk_state("w4 mid");
        output_spikes = 2'b00; step_tick = 1'b1; model_step(2'b00);
        cyc();
        chk("w4 valid one cycle after step", {31'd0, result_valid}, 32'd1);
        chk("w4 result", {14'd0, result_data}, {14'd0, 2'b01, 8'd1, 8'd3});
        chk_state("w4 end");
        step_tick = 1'b0; cyc();
        pop_chk("w4 pop");
        chk_state("w4 drained");

        // 256-step window with saturation
        window_len = 8'd0;
        for (int i = 0; i < 255; i++) do_step(2'b11);
        chk_state("w256 at 255");
        do_step(2'b11);
        chk("w256 result", {14'd0, result_data}, {14'd0, 2'b11, 8'd255, 8'd255});
        pop_chk("w256 pop");

        // five 1-step windows, no reads: fifth dropped
        window_len = 8'd1;
        do_step(2'b01); do_step(2'b10); do_step(2'b11); do_step(2'b00);
        chk("full no overflow yet", {31'd0, overflow}, 32'd0);
        do_step(2'b01);
        chk_state("overflow");
        chk("overflow set", {31'd0, overflow}, 32'd1);
        step_pop("full write+pop", 2'b10);
        chk_state("full write+pop");
        for (int i = 0; i < 4; i++) pop_chk("drain");
        chk_state("drained");

        // enable gating and held tick
        window_len = 8'd10;
        do_step(2'b01); do_step(2'b11); do_step(2'b10);
        enable = 1'b0;
        do_step(2'b11); do_step(2'b11); do_step(2'b11);
        chk_state("disabled steps");
        output_spikes = 2'b11; step_tick = 1'b1;
        cyc();
        enable = 1'b1;
        cyc(); cyc();
        chk_state("held tick");
        step_tick = 1'b0; output_spikes = 2'b00;
        cyc();
        do_step(2'b00); do_step(2'b01);
        chk_state("idx5");
        window_len = 8'd2;
        do_step(2'b10);
        chk_state("shrink closes");
        chk("shrink result", {14'd0, result_data}, {14'd0, 2'b11, 8'd3, 8'd3});
        pop_chk("shrink pop");

        // async reset mid-window with two entries queued
        window_len = 8'd3;
        for (int i = 0; i < 7; i++) do_step(2'b01);
        chk_state("pre-reset");
        reset = 1'b1;
        #2;
        chk_all_zero("async reset");
        exp_q.delete();
        m_c0 = 0; m_c1 = 0; m_idx = 0; m_ovf = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        do_step(2'b10); do_step(2'b10); do_step(2'b00);
        chk("post-reset result", {14'd0, result_data}, {14'd0, 2'b10, 8'd2, 8'd0});
        pop_chk("post-reset pop");
        chk_state("final");
        chk("final empty data", {14'd0, result_data}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
